// File: rtl/pw_lockout.sv
// Lockout/open timer that sits behind the password FSM: counts consecutive failures,
// locks or opens for a timed interval and shows the seconds countdown on two 7-seg digits.
// Optional build macro PW_LOCKOUT_ESCALATE_EN doubles the lockout length per level (up to ESC_MAX).
module pw_lockout #(
  parameter int CLK_FREQ     = 10,
  parameter int MAX_FAILS    = 3,
  parameter int LOCK_SECONDS = 30,
  parameter int OPEN_SECONDS = 10,
  parameter int ESC_MAX      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       attempt_ok,
  input  logic       attempt_bad,
  input  logic       relock,
  output logic       lock,
  output logic       open,
  output logic [3:0] fail_cnt,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  localparam int CNT_W = $clog2(99 << ESC_MAX) + 1;
  localparam int PRE_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLK_FREQ - 1);
  localparam logic [CNT_W-1:0] OPEN_LEN  = CNT_W'(OPEN_SECONDS);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(99);
  localparam logic [3:0]       FAIL_TRIP = 4'(MAX_FAILS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OPEN   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       fail_q, fail_d;
  logic             lock_q, lock_d;
  logic             open_q, open_d;
  logic [6:0]       hex1_q, hex1_d;
  logic [6:0]       hex0_q, hex0_d;

  logic             tick;
  logic             expire;
  logic [CNT_W-1:0] lock_len;
  logic [6:0]       sat;
  logic [6:0]       tens;
  logic [6:0]       units;

  function automatic logic [6:0] seg7(input logic [6:0] d);
    logic [6:0] s;
    case (d)
      7'd0:    s = 7'h40;
      7'd1:    s = 7'h79;
      7'd2:    s = 7'h24;
      7'd3:    s = 7'h30;
      7'd4:    s = 7'h19;
      7'd5:    s = 7'h12;
      7'd6:    s = 7'h02;
      7'd7:    s = 7'h78;
      7'd8:    s = 7'h00;
      7'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

`ifdef PW_LOCKOUT_ESCALATE_EN
  localparam int LVL_W = (ESC_MAX > 0) ? $clog2(ESC_MAX + 1) : 1;
  localparam logic [LVL_W-1:0] LVL_TOP = LVL_W'(ESC_MAX);

  logic [LVL_W-1:0] lvl_q, lvl_d;

  assign lock_len = CNT_W'(LOCK_SECONDS) << lvl_q;
`else
  assign lock_len = CNT_W'(LOCK_SECONDS);
`endif

  // The second tick counter only runs while a timed state is active.
  assign tick   = (state_q != S_IDLE) && (pre_q == PRE_LAST);
  assign expire = tick && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
`ifdef PW_LOCKOUT_ESCALATE_EN
    lvl_d   = lvl_q;
`endif

    case (state_q)
      S_IDLE: begin
        pre_d = '0;
        cnt_d = '0;
        if (attempt_ok) begin
          state_d = S_OPEN;
          fail_d  = 4'd0;
          cnt_d   = OPEN_LEN;
`ifdef PW_LOCKOUT_ESCALATE_EN
          lvl_d   = '0;
`endif
        end else if (attempt_bad) begin
          if (fail_q + 4'd1 == FAIL_TRIP) begin
            state_d = S_LOCKED;
            fail_d  = 4'd0;
            cnt_d   = lock_len;
          end else begin
            fail_d  = fail_q + 4'd1;
          end
        end
      end

      S_OPEN: begin
        if (relock) begin
          state_d = S_IDLE;
          pre_d   = '0;
          cnt_d   = '0;
        end else begin
          pre_d = tick ? '0 : pre_q + PRE_W'(1);
          if (tick && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
          if (expire) begin
            state_d = S_IDLE;
          end
        end
      end

      S_LOCKED: begin
        pre_d = tick ? '0 : pre_q + PRE_W'(1);
        if (tick && cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (expire) begin
          state_d = S_IDLE;
`ifdef PW_LOCKOUT_ESCALATE_EN
          if (lvl_q != LVL_TOP) begin
            lvl_d = lvl_q + LVL_W'(1);
          end
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
        pre_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are computed from next state so they change on the same edge as the FSM.
  always_comb begin
    lock_d = (state_d == S_LOCKED);
    open_d = (state_d == S_OPEN);
    sat    = (cnt_d > CNT_SAT) ? 7'd99 : cnt_d[6:0];
    tens   = sat / 7'd10;
    units  = sat % 7'd10;
    if (state_d == S_IDLE) begin
      hex1_d = 7'h7F;
      hex0_d = 7'h7F;
    end else begin
      hex1_d = seg7(tens);
      hex0_d = seg7(units);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= 4'd0;
      lock_q  <= 1'b0;
      open_q  <= 1'b0;
      hex1_q  <= 7'h7F;
      hex0_q  <= 7'h7F;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
      open_q  <= open_d;
      hex1_q  <= hex1_d;
      hex0_q  <= hex0_d;
    end
  end

`ifdef PW_LOCKOUT_ESCALATE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_q <= '0;
    end else begin
      lvl_q <= lvl_d;
    end
  end
`endif

  assign lock     = lock_q;
  assign open     = open_q;
  assign fail_cnt = fail_q;
  assign HEX1     = hex1_q;
  assign HEX0     = hex0_q;

endmodule
